// File: rtl/xrv_id.sv
// xrv_id: RV32I instruction-decode stage.
//
// Registers one decompressed instruction from fetch and presents its decoded
// fields to execute. It also tracks destination registers of loads that have
// left ID but have not yet written back, and raises stalling on a load-use hazard.
//
// Ports
//   clk, rstb                  clock; asynchronous active-low reset
//   inst, inst_pc              instruction from fetch and its PC
//   inst_is_compressed         inst came from a 16-bit encoding (PC step of 2)
//   inst_valid                 fetch pops inst this cycle (already gated by stalling)
//   stalling                   backpressure to fetch
//   jmp                        flush from execute
//   ex_ready                   execute accepts the ID register this cycle
//   ld_done, ld_rd             load writeback of register ld_rd completes
//   id_*                       registered decode results; id_valid qualifies them
//
// Handshake: fetch -> ID transfers when inst_valid=1 and jmp=0 (fetch has
// already suppressed inst_valid while stalling=1). ID -> EX transfers when
// id_valid=1, ex_ready=1 and jmp=0. While id_valid=1 and ex_ready=0 every id_*
// output holds. jmp kills the ID contents and blocks both transfers that cycle.
module xrv_id (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] inst,
  input  logic [31:0] inst_pc,
  input  logic        inst_is_compressed,
  input  logic        inst_valid,
  output logic        stalling,
  input  logic        jmp,
  input  logic        ex_ready,
  input  logic        ld_done,
  input  logic [4:0]  ld_rd,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_next,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [2:0]  id_funct3,
  output logic        id_funct7b5,
  output logic [31:0] id_imm,
  output logic [6:0]  id_opcode,
  output logic        id_is_load,
  output logic        id_is_store,
  output logic        id_is_branch,
  output logic        id_is_jal,
  output logic        id_is_jalr,
  output logic        id_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Combinational decode of the incoming instruction
  logic        d_has_rs1, d_has_rs2, d_has_rd;
  logic        d_load, d_store, d_branch, d_jal, d_jalr, d_illegal;
  logic [31:0] d_imm;
  logic [4:0]  d_rd, d_rs1, d_rs2;

  always_comb begin
    d_has_rs1 = 1'b1;
    d_has_rs2 = 1'b0;
    d_has_rd  = 1'b1;
    d_load    = 1'b0;
    d_store   = 1'b0;
    d_branch  = 1'b0;
    d_jal     = 1'b0;
    d_jalr    = 1'b0;
    d_illegal = 1'b0;
    d_imm     = 32'd0;
    case (inst[6:0])
      OP_LUI, OP_AUIPC: begin
        d_has_rs1 = 1'b0;
        d_imm     = {inst[31:12], 12'd0};
      end
      OP_JAL: begin
        d_has_rs1 = 1'b0;
        d_jal     = 1'b1;
        d_imm     = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_JALR: begin
        d_jalr = 1'b1;
        d_imm  = {{20{inst[31]}}, inst[31:20]};
      end
      OP_BRANCH: begin
        d_has_rs2 = 1'b1;
        d_has_rd  = 1'b0;
        d_branch  = 1'b1;
        d_imm     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LOAD: begin
        d_load = 1'b1;
        d_imm  = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        d_has_rs2 = 1'b1;
        d_has_rd  = 1'b0;
        d_store   = 1'b1;
        d_imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_IMM: d_imm = {{20{inst[31]}}, inst[31:20]};
      OP_OP:  d_has_rs2 = 1'b1;
      OP_MISC, OP_SYSTEM: d_imm = 32'd0;
      default: d_illegal = 1'b1;
    endcase
    // 16-bit encodings must have been expanded by fetch
    if (inst[1:0] != 2'b11) d_illegal = 1'b1;
  end

  assign d_rd  = d_has_rd  ? inst[11:7]  : 5'd0;
  assign d_rs1 = d_has_rs1 ? inst[19:15] : 5'd0;
  assign d_rs2 = d_has_rs2 ? inst[24:20] : 5'd0;

  // Loads that have left ID but not yet written back; bit 0 is never set
  logic [31:0] pending, pending_nxt;

  logic capture, handoff;
  assign capture = inst_valid & ~jmp;
  assign handoff = id_valid & ex_ready & ~jmp;

  // Set is applied after clear so a same-cycle set/clear of one register keeps
  // it pending. jmp only blocks the handoff; loads already in flight still
  // retire through ld_done.
  always_comb begin
    pending_nxt = pending;
    if (ld_done) pending_nxt[ld_rd] = 1'b0;
    if (handoff && id_is_load && (id_rd != 5'd0)) pending_nxt[id_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // A source hits if a load to it is in flight or is sitting in ID right now
  logic rs1_hit, rs2_hit, hazard;
  assign rs1_hit = (d_rs1 != 5'd0) &&
                   (pending[d_rs1] || (id_valid && id_is_load && (id_rd == d_rs1)));
  assign rs2_hit = (d_rs2 != 5'd0) &&
                   (pending[d_rs2] || (id_valid && id_is_load && (id_rd == d_rs2)));
  assign hazard  = rs1_hit | rs2_hit;

  assign stalling = (id_valid & ~ex_ready) | hazard;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pending      <= 32'd0;
      id_valid     <= 1'b0;
      id_pc        <= 32'd0;
      id_pc_next   <= 32'd0;
      id_rd        <= 5'd0;
      id_rs1       <= 5'd0;
      id_rs2       <= 5'd0;
      id_funct3    <= 3'd0;
      id_funct7b5  <= 1'b0;
      id_imm       <= 32'd0;
      id_opcode    <= 7'd0;
      id_is_load   <= 1'b0;
      id_is_store  <= 1'b0;
      id_is_branch <= 1'b0;
      id_is_jal    <= 1'b0;
      id_is_jalr   <= 1'b0;
      id_illegal   <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (jmp)          id_valid <= 1'b0;
      else if (capture) id_valid <= 1'b1;
      else if (handoff) id_valid <= 1'b0;
      if (capture) begin
        id_pc        <= inst_pc;
        id_pc_next   <= inst_pc + (inst_is_compressed ? 32'd2 : 32'd4);
        id_rd        <= d_rd;
        id_rs1       <= d_rs1;
        id_rs2       <= d_rs2;
        id_funct3    <= inst[14:12];
        id_funct7b5  <= inst[30];
        id_imm       <= d_imm;
        id_opcode    <= inst[6:0];
        id_is_load   <= d_load;
        id_is_store  <= d_store;
        id_is_branch <= d_branch;
        id_is_jal    <= d_jal;
        id_is_jalr   <= d_jalr;
        id_illegal   <= d_illegal;
      end
    end
  end

endmodule

// File: tb/tb_xrv_id.sv
// Testbench for xrv_id: decode vector table, hand-written pipeline corner
// sequences, then randomized traffic against a cycle-level reference model.
module tb_xrv_id;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] inst, inst_pc;
  logic        inst_is_compressed, inst_valid, stalling, jmp, ex_ready, ld_done;
  logic [4:0]  ld_rd;
  logic        id_valid;
  logic [31:0] id_pc, id_pc_next, id_imm;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [6:0]  id_opcode;
  logic        id_is_load, id_is_store, id_is_branch, id_is_jal, id_is_jalr, id_illegal;

  always #5 clk = ~clk;

  xrv_id dut (
    .clk(clk), .rstb(rstb), .inst(inst), .inst_pc(inst_pc),
    .inst_is_compressed(inst_is_compressed), .inst_valid(inst_valid),
    .stalling(stalling), .jmp(jmp), .ex_ready(ex_ready), .ld_done(ld_done),
    .ld_rd(ld_rd), .id_valid(id_valid), .id_pc(id_pc), .id_pc_next(id_pc_next),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_imm(id_imm), .id_opcode(id_opcode),
    .id_is_load(id_is_load), .id_is_store(id_is_store), .id_is_branch(id_is_branch),
    .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_illegal(id_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic [6:0]  op;
    logic        ld, st, br, jal, jalr, ill;
  } dec_t;

  dec_t act_d;
  assign act_d = {id_pc, id_pc_next, id_rd, id_rs1, id_rs2, id_funct3, id_funct7b5,
                  id_imm, id_opcode, id_is_load, id_is_store, id_is_branch,
                  id_is_jal, id_is_jalr, id_illegal};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  // Decode from the ISA field rules; immediates rebuilt with integer arithmetic
  function automatic dec_t ref_decode(input logic [31:0] i, input logic [31:0] pc, input logic c);
    dec_t d;
    byte  fmt;
    int   v;
    d = '0;
    d.pc      = pc;
    d.pc_next = pc + 32'(c ? 2 : 4);
    d.op      = i[6:0];
    d.f3      = i[14:12];
    d.f7b5    = i[30];
    case (i[6:0])
      7'h37, 7'h17: fmt = "U";
      7'h6F: begin fmt = "J"; d.jal = 1'b1; end
      7'h67: begin fmt = "I"; d.jalr = 1'b1; end
      7'h63: begin fmt = "B"; d.br = 1'b1; end
      7'h03: begin fmt = "I"; d.ld = 1'b1; end
      7'h23: begin fmt = "S"; d.st = 1'b1; end
      7'h13: fmt = "I";
      7'h33: fmt = "R";
      7'h0F, 7'h73: fmt = "N";
      default: begin fmt = "X"; d.ill = 1'b1; end
    endcase
    if (i[1:0] != 2'b11) d.ill = 1'b1;
    d.rs1 = (fmt == "U" || fmt == "J") ? 5'd0 : i[19:15];
    d.rs2 = (fmt == "R" || fmt == "S" || fmt == "B") ? i[24:20] : 5'd0;
    d.rd  = (fmt == "S" || fmt == "B") ? 5'd0 : i[11:7];
    case (fmt)
      "I": v = sx(int'(i[31:20]), 12);
      "S": v = sx(int'(i[31:25]) * 32 + int'(i[11:7]), 12);
      "B": v = sx(int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                  + int'(i[11:8]) * 2, 13);
      "U": v = int'(i & 32'hFFFFF000);
      "J": v = sx(int'(i[31]) * (1 << 20) + int'(i[19:12]) * (1 << 12)
                  + int'(i[20]) * (1 << 11) + int'(i[30:21]) * 2, 21);
      default: v = 0;
    endcase
    d.imm = 32'(v);
    return d;
  endfunction

  logic        m_v;
  dec_t        m_cur;
  logic [31:0] m_pend;

  function automatic logic ref_stall(input logic [31:0] i, input logic exr);
    dec_t d;
    logic hz;
    d  = ref_decode(i, 32'd0, 1'b0);
    hz = 1'b0;
    if (d.rs1 != 0 && (m_pend[d.rs1] || (m_v && m_cur.ld && m_cur.rd == d.rs1))) hz = 1'b1;
    if (d.rs2 != 0 && (m_pend[d.rs2] || (m_v && m_cur.ld && m_cur.rd == d.rs2))) hz = 1'b1;
    return (m_v && !exr) || hz;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst = 32'h00000013; inst_pc = 32'd0; inst_is_compressed = 1'b0;
    inst_valid = 1'b0; jmp = 1'b0; ex_ready = 1'b1; ld_done = 1'b0; ld_rd = 5'd0;
  endtask

  task automatic do_reset();
    idle();
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        c;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] pcn;
    logic        ill;
  } vec_t;

  localparam logic [31:0] LW5   = 32'h00012283;
  localparam logic [31:0] LW7   = 32'h00012383;
  localparam logic [31:0] ADD6  = 32'h00128333;
  localparam logic [31:0] ADDI1 = 32'h00500093;
  localparam logic [31:0] ADDI9 = 32'h00100493;
  localparam logic [31:0] USE5  = 32'h00028513;
  localparam logic [31:0] USE7  = 32'h00038513;

  vec_t vecs[10];
  logic [6:0] ops[11];

  initial begin
    vecs[0] = '{ADDI1,        32'h100,      0, 1, 0, 0, 32'h5,        32'h104, 0};
    vecs[1] = '{LW5,          32'h200,      0, 5, 2, 0, 32'h0,        32'h204, 0};
    vecs[2] = '{32'hFE612E23, 32'h300,      0, 0, 2, 6, 32'hFFFFFFFC, 32'h304, 0};
    vecs[3] = '{32'hFE208CE3, 32'h400,      0, 0, 1, 2, 32'hFFFFFFF8, 32'h404, 0};
    vecs[4] = '{32'h123451B7, 32'h500,      0, 3, 0, 0, 32'h12345000, 32'h504, 0};
    vecs[5] = '{32'hFFDFF06F, 32'h1000,     0, 0, 0, 0, 32'hFFFFFFFC, 32'h1004, 0};
    vecs[6] = '{ADD6,         32'h600,      0, 6, 5, 1, 32'h0,        32'h604, 0};
    vecs[7] = '{ADDI1,        32'hFFFFFFFE, 1, 1, 0, 0, 32'h5,        32'h0,   0};
    vecs[8] = '{32'h00000000, 32'h40,       1, 0, 0, 0, 32'h0,        32'h42,  1};
    vecs[9] = '{32'hFFF100E7, 32'h700,      0, 1, 2, 0, 32'hFFFFFFFF, 32'h704, 0};
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    // Reset state
    idle();
    rstb = 1'b0;
    #2;
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_outs", act_d, '0);
    chk("rst_stall", stalling, 1'b0);
    tick();
    rstb = 1'b1;
    #1;
    chk("post_rst_stall", stalling, 1'b0);

    // Decode table
    for (int k = 0; k < 10; k++) begin
      inst = vecs[k].inst; inst_pc = vecs[k].pc; inst_is_compressed = vecs[k].c;
      inst_valid = 1'b1; ex_ready = 1'b1;
      tick();
      inst_valid = 1'b0;
      chk($sformatf("vec%0d_valid", k), id_valid, 1'b1);
      chk($sformatf("vec%0d_rd", k), id_rd, vecs[k].rd);
      chk($sformatf("vec%0d_rs1", k), id_rs1, vecs[k].rs1);
      chk($sformatf("vec%0d_rs2", k), id_rs2, vecs[k].rs2);
      chk($sformatf("vec%0d_imm", k), id_imm, vecs[k].imm);
      chk($sformatf("vec%0d_pcn", k), id_pc_next, vecs[k].pcn);
      chk($sformatf("vec%0d_ill", k), id_illegal, vecs[k].ill);
    end

    // Load-use: lw x5 then add x6,x5,x1
    do_reset();
    inst = LW5; inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0; inst = ADD6;
    #1 chk("lu_stall_in_id", stalling, 1'b1);
    tick();
    chk("lu_handed_off", id_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lu_stall_pend%0d", k), stalling, 1'b1);
      tick();
    end
    ld_done = 1'b1; ld_rd = 5'd5;
    #1 chk("lu_stall_at_done", stalling, 1'b1);
    tick();
    ld_done = 1'b0;
    chk("lu_stall_released", stalling, 1'b0);
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("lu_cap_valid", id_valid, 1'b1);
    chk("lu_cap_rd", id_rd, 5'd6);
    chk("lu_cap_rs1", id_rs1, 5'd5);

    // Execute backpressure: outputs hold, single handoff
    do_reset();
    inst = ADDI1; inst_pc = 32'h100; inst_valid = 1'b1; ex_ready = 1'b0;
    tick();
    inst_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inst = $urandom; inst_pc = $urandom;
      #1;
      chk($sformatf("bp_valid%0d", k), id_valid, 1'b1);
      chk($sformatf("bp_outs%0d", k), act_d, ref_decode(ADDI1, 32'h100, 1'b0));
      chk($sformatf("bp_stall%0d", k), stalling, 1'b1);
      tick();
    end
    inst = 32'h00000013; ex_ready = 1'b1;
    #1 chk("bp_release_stall", stalling, 1'b0);
    tick();
    chk("bp_handoff", id_valid, 1'b0);
    tick();
    chk("bp_stays_empty", id_valid, 1'b0);

    // Flush coincident with capture and handoff
    do_reset();
    inst = LW5; inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    inst = LW7;
    #1 chk("jmp_pre_stall", stalling, 1'b0);
    inst_valid = 1'b1;
    tick();
    inst = ADDI9; jmp = 1'b1;
    tick();
    jmp = 1'b0; inst_valid = 1'b0;
    chk("jmp_valid", id_valid, 1'b0);
    chk("jmp_no_capture", id_rd, 5'd7);
    inst = USE5;
    #1 chk("jmp_pend5_kept", stalling, 1'b1);
    inst = USE7;
    #1 chk("jmp_no_pend7", stalling, 1'b0);

    // Reset while a valid instruction is held
    inst = ADDI1; inst_valid = 1'b1; ex_ready = 1'b0;
    tick();
    inst_valid = 1'b0; inst = USE5;
    chk("midrst_pre_valid", id_valid, 1'b1);
    #2 rstb = 1'b0;
    #1;
    chk("midrst_valid", id_valid, 1'b0);
    chk("midrst_outs", act_d, '0);
    chk("midrst_stall", stalling, 1'b0);
    tick();
    rstb = 1'b1; ex_ready = 1'b1;
    #1 chk("midrst_pend_cleared", stalling, 1'b0);
    tick();
    chk("midrst_no_handoff", id_valid, 1'b0);

    // Randomized traffic against the model
    do_reset();
    m_v = 1'b0; m_cur = '0; m_pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        exp_st, nv, handoff, cap;
      logic [31:0] np;
      dec_t        nc;
      chk("rand_valid", id_valid, m_v);
      chk("rand_outs", act_d, m_cur);
      if ($urandom_range(0, 15) == 0) inst = $urandom;
      else inst = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   3'($urandom), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 10)]};
      inst_pc = $urandom; inst_is_compressed = 1'($urandom);
      jmp = ($urandom_range(0, 9) == 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      ld_done = ($urandom_range(0, 3) == 0);
      ld_rd = 5'($urandom_range(0, 7));
      exp_st = ref_stall(inst, ex_ready);
      inst_valid = !exp_st && ($urandom_range(0, 3) != 0);
      #1 chk("rand_stall", stalling, exp_st);
      handoff = m_v && ex_ready && !jmp;
      cap = inst_valid && !jmp;
      np = m_pend;
      if (ld_done) np[ld_rd] = 1'b0;
      if (handoff && m_cur.ld && m_cur.rd != 0) np[m_cur.rd] = 1'b1;
      np[0] = 1'b0;
      nv = jmp ? 1'b0 : cap ? 1'b1 : handoff ? 1'b0 : m_v;
      nc = cap ? ref_decode(inst, inst_pc, inst_is_compressed) : m_cur;
      tick();
      m_v = nv; m_cur = nc; m_pend = np;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
